// File: rtl/adpcm_stream_sequencer_if.sv
// Code-in / byte-out bundle between the ADPCM compressor, the stream
// sequencer and the downstream serializer.
interface adpcm_stream_sequencer_if;
   logic       enc_valid;
   logic [3:0] enc_pcm;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_ready;

   modport master (
      input  enc_valid,
      input  enc_pcm,
      input  byte_ready,
      output byte_data,
      output byte_valid
   );

   modport slave (
      output enc_valid,
      output enc_pcm,
      output byte_ready,
      input  byte_data,
      input  byte_valid
   );
endinterface

// File: rtl/adpcm_stream_sequencer.sv
// ADPCM stream sequencer: slow clock divider, warm-up gating, nibble packing
// into framed bytes (sync, frame count, payload) and a small output byte FIFO.
module adpcm_stream_sequencer #(
   parameter int unsigned DECIM      = 64,
   parameter int unsigned WARMUP     = 4,
   parameter int unsigned FRAME_LEN  = 32,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic stop,
   output logic slow_clk,
   output logic block_enable,
   output logic busy,
   output logic overflow,
   adpcm_stream_sequencer_if.master bus
);
   localparam int unsigned DW = $clog2(DECIM);
   localparam int unsigned WW = $clog2(WARMUP + 1);
   localparam int unsigned NW = $clog2(FRAME_LEN);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ARM      = 3'd1,
      S_HDR_SYNC = 3'd2,
      S_HDR_CNT  = 3'd3,
      S_STREAM   = 3'd4
   } state_t;

   state_t        state_r;
   logic [DW-1:0] div_cnt_r, div_next_s;
   logic          slow_clk_r, tick_s;
   logic [WW-1:0] warm_cnt_r;
   logic [7:0]    frame_cnt_r;
   logic [NW-1:0] nib_cnt_r;
   logic [3:0]    low_nib_r;
   logic          stop_pending_r, block_enable_r, busy_r, overflow_r;
   logic          push_s, hdr_drop_s, pop_s, full_s, accept_s, drop_s;
   logic [7:0]    push_data_s, head_next_s, byte_data_r;
   logic          byte_valid_r;
   logic [7:0]    mem_r [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_r, wr_ptr_r, rd_next_s;
   logic [CW-1:0] count_r, count_next_s, remain_s;

   // divider next count and end-of-period tick
   always_comb begin
      tick_s = (div_cnt_r == DW'(DECIM - 1));
      if (tick_s) begin
         div_next_s = {DW{1'b0}};
      end else begin
         div_next_s = div_cnt_r + DW'(1'b1);
      end
   end

   // free-running divider; slow_clk tracks the count it is registered alongside
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_r  <= {DW{1'b0}};
         slow_clk_r <= 1'b0;
      end else begin
         div_cnt_r  <= div_next_s;
         slow_clk_r <= (div_next_s >= DW'(DECIM / 2));
      end
   end

   // sequencing FSM with registered enable/busy
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= S_IDLE;
         block_enable_r <= 1'b0;
         busy_r         <= 1'b0;
         warm_cnt_r     <= {WW{1'b0}};
         frame_cnt_r    <= 8'h00;
         nib_cnt_r      <= {NW{1'b0}};
         low_nib_r      <= 4'h0;
         stop_pending_r <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  state_r        <= S_ARM;
                  block_enable_r <= 1'b1;
                  busy_r         <= 1'b1;
                  warm_cnt_r     <= {WW{1'b0}};
                  frame_cnt_r    <= 8'h00;
                  stop_pending_r <= 1'b0;
               end
            end
            S_ARM: begin
               if (stop) begin
                  state_r        <= S_IDLE;
                  block_enable_r <= 1'b0;
                  busy_r         <= 1'b0;
               end else if (tick_s) begin
                  warm_cnt_r <= warm_cnt_r + WW'(1'b1);
                  if (warm_cnt_r == WW'(WARMUP - 1)) begin
                     state_r <= S_HDR_SYNC;
                  end
               end
            end
            S_HDR_SYNC: begin
               if (stop) stop_pending_r <= 1'b1;
               state_r <= S_HDR_CNT;
            end
            S_HDR_CNT: begin
               if (stop) stop_pending_r <= 1'b1;
               state_r   <= S_STREAM;
               nib_cnt_r <= {NW{1'b0}};
            end
            S_STREAM: begin
               if (stop) stop_pending_r <= 1'b1;
               if (bus.enc_valid) begin
                  if (!nib_cnt_r[0]) low_nib_r <= bus.enc_pcm;
                  if (nib_cnt_r == NW'(FRAME_LEN - 1)) begin
                     nib_cnt_r   <= {NW{1'b0}};
                     frame_cnt_r <= frame_cnt_r + 8'd1;
                     // a stop arriving with the closing code also ends here
                     if (stop_pending_r || stop) begin
                        state_r        <= S_IDLE;
                        block_enable_r <= 1'b0;
                        busy_r         <= 1'b0;
                        stop_pending_r <= 1'b0;
                     end else begin
                        state_r <= S_HDR_SYNC;
                     end
                  end else begin
                     nib_cnt_r <= nib_cnt_r + NW'(1'b1);
                  end
               end
            end
            default: begin
               state_r        <= S_IDLE;
               block_enable_r <= 1'b0;
               busy_r         <= 1'b0;
            end
         endcase
      end
   end

   // byte producer: header bytes and completed nibble pairs
   always_comb begin
      push_s      = 1'b0;
      push_data_s = 8'h00;
      hdr_drop_s  = 1'b0;
      case (state_r)
         S_HDR_SYNC: begin
            push_s      = 1'b1;
            push_data_s = SYNC_BYTE;
            hdr_drop_s  = bus.enc_valid;
         end
         S_HDR_CNT: begin
            push_s      = 1'b1;
            push_data_s = frame_cnt_r;
            hdr_drop_s  = bus.enc_valid;
         end
         S_STREAM: begin
            push_s      = bus.enc_valid && nib_cnt_r[0];
            push_data_s = {bus.enc_pcm, low_nib_r};
         end
         default: begin
            push_s      = 1'b0;
            push_data_s = 8'h00;
         end
      endcase
   end

   // FIFO bookkeeping and next head value so outputs can be registered
   always_comb begin
      pop_s        = byte_valid_r && bus.byte_ready;
      full_s       = (count_r == CW'(FIFO_DEPTH));
      accept_s     = push_s && (!full_s || pop_s);
      drop_s       = (push_s && !accept_s) || hdr_drop_s;
      remain_s     = pop_s ? (count_r - CW'(1'b1)) : count_r;
      count_next_s = accept_s ? (remain_s + CW'(1'b1)) : remain_s;
      rd_next_s    = pop_s ? (rd_ptr_r + AW'(1'b1)) : rd_ptr_r;
      if (count_next_s == {CW{1'b0}}) begin
         head_next_s = 8'h00;
      end else if (remain_s == {CW{1'b0}}) begin
         head_next_s = push_data_s;
      end else begin
         head_next_s = mem_r[rd_next_s];
      end
   end

   // FIFO pointers, registered head/valid and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_r     <= {AW{1'b0}};
         wr_ptr_r     <= {AW{1'b0}};
         count_r      <= {CW{1'b0}};
         byte_valid_r <= 1'b0;
         byte_data_r  <= 8'h00;
         overflow_r   <= 1'b0;
      end else begin
         rd_ptr_r     <= rd_next_s;
         count_r      <= count_next_s;
         byte_valid_r <= (count_next_s != {CW{1'b0}});
         byte_data_r  <= head_next_s;
         if (accept_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         if ((state_r == S_IDLE) && start) begin
            overflow_r <= 1'b0;
         end else if (drop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // FIFO storage; entries are meaningful only while counted
   always_ff @(posedge clk) begin
      if (accept_s) mem_r[wr_ptr_r] <= push_data_s;
   end

   assign slow_clk       = slow_clk_r;
   assign block_enable   = block_enable_r;
   assign busy           = busy_r;
   assign overflow       = overflow_r;
   assign bus.byte_data  = byte_data_r;
   assign bus.byte_valid = byte_valid_r;
endmodule

// File: doc/adpcm_stream_sequencer.md
Name: adpcm_stream_sequencer

Overview:
- Controller for the CIC/ADPCM compressor.
- Generates the compressor's slow_clk and block_enable, discards codes while the CIC filter warms up, and packs 4-bit ADPCM codes into framed bytes.
- Each frame is a sync byte, a frame counter byte, then FRAME_LEN/2 packed code bytes.
- Bytes are buffered in a small FIFO with a valid/ready output toward the serializer/host interface.

Parameters:
- DECIM, 64: clk cycles per slow_clk period; even, ≥4.
- WARMUP, 4: slow_clk periods discarded after enable.
- FRAME_LEN, 32: nibbles per frame; even, ≤256.
- SYNC_BYTE, 8'hA5: first byte of every frame.
- FIFO_DEPTH, 4: output byte FIFO entries; power of two.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  pulse; begin streaming.
- stop  in  1  pulse; end streaming at the next frame boundary.
- slow_clk  out  1  divided clock to the compressor.
- block_enable  out  1  compressor enable.
- enc_valid  in  1  compressor outValid, synchronous to clk, single-cycle pulse.
- enc_pcm  in  4  compressor encPcm; sampled when enc_valid=1.
- byte_data  out  8  FIFO head byte.
- byte_valid  out  1  FIFO not empty.
- byte_ready  in  1  consumer accepts byte_data.
- busy  out  1  state != IDLE.
- overflow  out  1  sticky; a byte or code was dropped.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs are 0 and the FIFO is empty.
  - state=IDLE; div_cnt=0; frame_cnt=0; nib_cnt=0; stop_pending=0.
- Divider:
  - div_cnt counts 0..DECIM-1 and wraps. It runs continuously after reset.
  - slow_clk is registered: 1 when div_cnt ≥ DECIM/2, otherwise 0.
  - tick is asserted when div_cnt==DECIM-1.
- IDLE:
  - block_enable=0.
  - start → ARM next cycle: block_enable=1, warm_cnt=0, frame_cnt=0, overflow cleared, stop_pending=0.
  - stop in IDLE is ignored.
- ARM:
  - Every tick increments warm_cnt. When warm_cnt reaches WARMUP → HEADER.
  - enc_valid is ignored (not an overflow).
  - stop → IDLE next cycle; block_enable=0 on that cycle.
- HEADER, exactly 2 cycles:
  - Cycle 1 pushes SYNC_BYTE.
  - Cycle 2 pushes frame_cnt, then → STREAM with nib_cnt=0.
  - enc_valid during HEADER is dropped and sets overflow.
- STREAM, on each enc_valid:
  - Even nib_cnt: hold enc_pcm in low_nib.
  - Odd nib_cnt: push {enc_pcm, low_nib}; the later code occupies bits [7:4].
  - nib_cnt increments on each code.
  - On the cycle the FRAME_LEN-th code is accepted:
    - frame_cnt increments (8-bit, 255 wraps to 0).
    - If stop_pending → IDLE; otherwise → HEADER.
  - A byte pushed in this cycle is always completed.
- stop:
  - In HEADER or STREAM, stop sets stop_pending. block_enable stays 1 until the frame completes.
  - start while busy is ignored.
  - start and stop in the same cycle: in IDLE, start acts; elsewhere, stop acts.
- FIFO:
  - byte_valid = !empty; byte_data = head, and is 0 when empty.
  - Pop when byte_valid && byte_ready.
  - Push when full without a same-cycle pop: byte dropped, overflow=1.
  - Push with a same-cycle pop while full: accepted, no overflow.
- Precondition: enc_valid pulses are ≥4 clk cycles apart.
- Latency: a pushed byte appears on byte_data/byte_valid the cycle after the push.
- rst mid-frame: the frame is abandoned, the FIFO is flushed, and block_enable drops on the next cycle.

Test Plan (DECIM=8, FRAME_LEN=4, WARMUP=2, FIFO_DEPTH=4):
- Divider: after reset, slow_clk is 0 for 4 cycles then 1 for 4 cycles, repeating. block_enable=0 and byte_valid=0 throughout.
- Single frame:
  - Stimulus: start, then codes 1,2,3,4 with byte_ready=1; codes are also sent during ARM.
  - Response: byte stream A5,00,21,43. block_enable rises 1 cycle after start. Codes sent during ARM produce no bytes.
- Stop at boundary:
  - Stimulus: stop after the 2nd code of frame 0, then codes 5,6.
  - Response: bytes A5,00,21,65. block_enable=0 the cycle after code 6; busy=0; no frame-1 header.
- Back-to-back frames:
  - Stimulus: 8 codes, 0..7.
  - Response: A5,00,10,32,A5,01,54,76. After 256 frames, frame_cnt wraps to 00.
- Backpressure:
  - Stimulus: byte_ready=0 for a whole frame.
  - Response: the first 4 bytes are held (A5,00,21,43); later pushes are dropped and overflow=1.
  - overflow stays 1 until the next start from IDLE.
- Stop in ARM, and rst mid-STREAM:
  - Stop in ARM returns to IDLE with no bytes output.
  - rst mid-STREAM gives byte_valid=0 and block_enable=0 the next cycle.
